// File: rtl/mult16_rr_scheduler.sv
// mult16_rr_scheduler: round-robin sharing of one Mult16x16 among N_REQ requesters.
// Optional build macro MULT_ZERO_BYPASS_EN: accepts with a zero operand skip the multiplier.

module mult16_rr_scheduler #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MULT_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic [15:0]           mult_a,
    output logic [15:0]           mult_b,
    input  logic [31:0]           mult_result,
    output logic                  busy
);

    localparam int              CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      mult_a_q, mult_a_d;
    logic [15:0]      mult_b_q, mult_b_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]      rsp_result_q, rsp_result_d;

    logic [15:0]      op_a [N_REQ];
    logic [15:0]      op_b [N_REQ];
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand_idx;
    logic [15:0]      grant_a;
    logic [15:0]      grant_b;
    logic             take_bypass;

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % N_REQ);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = req_a[16*i +: 16];
            op_b[i] = req_b[16*i +: 16];
        end
    end

    // Search starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = wrap_idx(int'(rr_ptr_q) + k);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant_a = op_a[grant_idx];
    assign grant_b = op_b[grant_idx];

`ifdef MULT_ZERO_BYPASS_EN
    assign take_bypass = (grant_a == 16'd0) || (grant_b == 16'd0);
`else
    assign take_bypass = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    rr_ptr_d = grant_idx;
                    rsp_id_d = grant_idx;
                    cnt_d    = '0;
                    if (take_bypass) begin
                        rsp_result_d = 32'd0;
                        state_d      = ST_RESP;
                    end else begin
                        mult_a_d = grant_a;
                        mult_b_d = grant_b;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Operands have been stable for MULT_LAT cycles once cnt reaches its last value.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    rsp_result_d = mult_result;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= PTR_INIT;
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;

endmodule

// File: tb/tb_mult16_rr_scheduler.sv
// tb_mult16_rr_scheduler: directed and randomized checks of the shared-multiplier scheduler
// against a transaction-timeline reference model and a pipelined multiplier stand-in.

module tb_mult16_rr_scheduler;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int MULT_LAT = 4;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_a = '0;
    logic [16*N_REQ-1:0] req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_result;
    logic [15:0]         mult_a;
    logic [15:0]         mult_b;
    logic [31:0]         mult_result;
    logic                busy;

    mult16_rr_scheduler #(
        .N_REQ    (N_REQ),
        .ID_W     (ID_W),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product becomes valid MULT_LAT-1 edges after the operands settle.
    logic [31:0] mpipe [MULT_LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= 32'(mult_a) * 32'(mult_b);
        for (int s = 1; s < MULT_LAT - 1; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mult_result = mpipe[MULT_LAT-2];

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] op_a [N_REQ];
    logic [15:0] op_b [N_REQ];
    int          stim_mode = 0;

    int          cyc = 0;
    bit          m_idle;
    bit          pend;
    int          pend_due;
    int          pend_id;
    logic [31:0] pend_prod;
    int          last_g;
    logic [15:0] exp_ma;
    logic [15:0] exp_mb;
    int          model_granted = -1;

    int          grant_ids[$];
    int          grant_cycles[$];
    int          rsp_first[$];
    int          rsp_ids[$];
    logic [31:0] rsp_results[$];
    bit          prev_valid = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N_REQ; k++) begin
            int idx = (last_g + k) % N_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic int get_log(input int kind, input int i);
        case (kind)
            0:       return (i < grant_ids.size())    ? grant_ids[i]    : -1;
            1:       return (i < grant_cycles.size()) ? grant_cycles[i] : -1;
            2:       return (i < rsp_first.size())    ? rsp_first[i]    : -1;
            default: return (i < rsp_ids.size())      ? rsp_ids[i]      : -1;
        endcase
    endfunction

    function automatic logic [31:0] get_result(input int i);
        return (i < rsp_results.size()) ? rsp_results[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int log_count(input int kind);
        case (kind)
            0:       return grant_ids.size();
            1:       return rsp_ids.size();
            default: return rsp_first.size();
        endcase
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
    endtask

    task automatic clear_logs();
        grant_ids.delete();
        grant_cycles.delete();
        rsp_first.delete();
        rsp_ids.delete();
        rsp_results.delete();
    endtask

    // Mode 1 drops a granted request, mode 2 re-arms it with fresh operands, mode 3 is fully random.
    task automatic applyStimulus();
        for (int i = 0; i < N_REQ; i++) begin
            if (model_granted == i) begin
                if (stim_mode == 1) req_valid[i] = 1'b0;
                if (stim_mode == 3) req_valid[i] = 1'($urandom_range(0, 1));
                op_a[i] = rand_op();
                op_b[i] = rand_op();
            end else if (stim_mode == 3) begin
                if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) == 0);
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (stim_mode == 3) rsp_ready = ($urandom_range(0, 3) != 0);
        pack_ops();
    endtask

    task automatic check_cycle();
        logic [N_REQ-1:0] exp_ready;
        bit               exp_valid;
        int               pick;
        if (rst) return;
        exp_ready = '0;
        pick = rr_pick();
        if (m_idle && pick >= 0) exp_ready[pick] = 1'b1;
        exp_valid = pend && (cyc >= pend_due);
        checkOutput("req_ready", req_ready, exp_ready);
        checkOutput("rsp_valid", rsp_valid, exp_valid);
        checkOutput("busy", busy, !m_idle);
        checkOutput("mult_a", mult_a, exp_ma);
        checkOutput("mult_b", mult_b, exp_mb);
        if (exp_valid) begin
            checkOutput("rsp_id", rsp_id, pend_id);
            checkOutput("rsp_result", rsp_result, pend_prod);
        end
    endtask

    task automatic log_dut();
        if (rst) begin
            prev_valid = 1'b0;
            return;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                grant_ids.push_back(i);
                grant_cycles.push_back(cyc);
            end
        end
        if (rsp_valid && !prev_valid) rsp_first.push_back(cyc);
        if (rsp_valid && rsp_ready) begin
            rsp_ids.push_back(int'(rsp_id));
            rsp_results.push_back(rsp_result);
        end
        prev_valid = rsp_valid;
    endtask

    task automatic model_edge();
        int g;
        bit zero;
        model_granted = -1;
        if (rst) begin
            m_idle = 1'b1;
            pend   = 1'b0;
            last_g = N_REQ - 1;
            exp_ma = '0;
            exp_mb = '0;
            return;
        end
        if (m_idle) begin
            g = rr_pick();
            if (g >= 0) begin
                zero      = BYPASS && (op_a[g] == 16'd0 || op_b[g] == 16'd0);
                m_idle    = 1'b0;
                pend      = 1'b1;
                pend_id   = g;
                pend_prod = 32'(op_a[g]) * 32'(op_b[g]);
                pend_due  = cyc + 1 + (zero ? 0 : MULT_LAT);
                if (!zero) begin
                    exp_ma = op_a[g];
                    exp_mb = op_b[g];
                end
                last_g        = g;
                model_granted = g;
            end
        end else if (pend && cyc >= pend_due && rsp_ready) begin
            pend   = 1'b0;
            m_idle = 1'b1;
        end
    endtask

    task automatic run_cycle();
        #2;
        check_cycle();
        log_dut();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (stim_mode != 0) applyStimulus();
    endtask

    task automatic run_until(input int kind, input int target, input int budget, input string tag);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            run_cycle();
            done = (log_count(kind) >= target);
        end
        checkOutput(tag, done, 1'b1);
    endtask

    task automatic check_reset_state();
        #1;
        checkOutput("rst_req_ready", req_ready, '0);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_id", rsp_id, '0);
        checkOutput("rst_rsp_result", rsp_result, 32'd0);
        checkOutput("rst_mult_a", mult_a, 16'd0);
        checkOutput("rst_mult_b", mult_b, 16'd0);
        checkOutput("rst_busy", busy, 1'b0);
    endtask

    task automatic do_reset(input int n);
        stim_mode = 0;
        req_valid = '0;
        rst = 1'b1;
        repeat (n) run_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int exp_alt [4]   = '{1, 3, 1, 3};
        int n0;
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        @(posedge clk);
        #1;

        // Single request from requester 0, 3*5.
        do_reset(2);
        check_reset_state();
        op_a[0] = 16'd3;
        op_b[0] = 16'd5;
        pack_ops();
        req_valid = 4'b0001;
        stim_mode = 1;
        clear_logs();
        run_until(1, 1, 20, "t1_response");
        checkOutput("t1_grant_count", grant_ids.size(), 1);
        checkOutput("t1_grant_id", get_log(0, 0), 0);
        checkOutput("t1_latency", get_log(2, 0) - get_log(1, 0), 1 + MULT_LAT);
        checkOutput("t1_result", get_result(0), 32'd15);
        checkOutput("t1_rsp_id", get_log(3, 0), 0);

        // Largest operands on requester 2.
        op_a[2] = 16'hFFFF;
        op_b[2] = 16'hFFFF;
        pack_ops();
        req_valid = 4'b0100;
        clear_logs();
        run_until(1, 1, 20, "t2_response");
        checkOutput("t2_result", get_result(0), 32'hFFFE_0001);
        checkOutput("t2_rsp_id", get_log(3, 0), 2);

        // All requesters continuously valid.
        do_reset(1);
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = rand_op();
            op_b[i] = rand_op();
        end
        pack_ops();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        stim_mode = 2;
        clear_logs();
        run_until(0, 5, 60, "t3_grants");
        for (int k = 0; k < 5; k++) checkOutput("t3_order", get_log(0, k), exp_order[k]);
        for (int k = 0; k < 4; k++) checkOutput("t3_spacing", get_log(1, k + 1) - get_log(1, k), MULT_LAT + 2);

        // Requesters 1 and 3 alternate; consumer stalls in RESP.
        do_reset(1);
        req_valid = 4'b1010;
        stim_mode = 2;
        clear_logs();
        run_until(0, 4, 40, "t4_grants");
        for (int k = 0; k < 4; k++) checkOutput("t4_order", get_log(0, k), exp_alt[k]);
        rsp_ready = 1'b0;
        n0 = log_count(2);
        run_until(2, n0 + 1, 20, "t4_rsp_arrives");
        repeat (9) run_cycle();
        checkOutput("t4_no_handshake_while_stalled", log_count(1), 3);
        rsp_ready = 1'b1;
        run_until(1, 4, 5, "t4_release");

        // Reset during the second WAIT cycle drops the in-flight op.
        do_reset(1);
        op_a[0] = rand_op();
        op_b[0] = 16'd7;
        pack_ops();
        req_valid = 4'b0001;
        stim_mode = 1;
        clear_logs();
        run_until(0, 1, 5, "t5_grant");
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        check_reset_state();
        op_a[1] = rand_op();
        op_b[1] = rand_op();
        op_a[3] = rand_op();
        op_b[3] = rand_op();
        pack_ops();
        req_valid = 4'b1010;
        clear_logs();
        run_until(0, 1, 5, "t5_grant_after_rst");
        checkOutput("t5_first_grant", get_log(0, 0), 1);
        run_until(1, 2, 30, "t5_drain");

        // Zero operand on requester 0.
        op_a[0] = 16'd0;
        op_b[0] = 16'd1234;
        pack_ops();
        req_valid = 4'b0001;
        clear_logs();
        run_until(1, 1, 20, "t6_response");
        checkOutput("t6_latency", get_log(2, 0) - get_log(1, 0), BYPASS ? 1 : 1 + MULT_LAT);
        checkOutput("t6_result", get_result(0), 32'd0);
        checkOutput("t6_rsp_id", get_log(3, 0), 0);

        // Random traffic with withdrawals and consumer back-pressure.
        stim_mode = 3;
        clear_logs();
        repeat (400) run_cycle();
        checkOutput("rand_made_progress", (grant_ids.size() > 10), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
